// File: rtl/exec_pkg.sv
// Shared constants for the execute stage: ALU opcodes, FSM encoding and
// iterative multiply/divide parameters.
package exec_pkg;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_NOR   = 4'd5;
   localparam logic [3:0] OP_SLT   = 4'd6;
   localparam logic [3:0] OP_SLTU  = 4'd7;
   localparam logic [3:0] OP_SLL   = 4'd8;
   localparam logic [3:0] OP_SRL   = 4'd9;
   localparam logic [3:0] OP_SRA   = 4'd10;
   localparam logic [3:0] OP_LUI   = 4'd11;
   localparam logic [3:0] OP_MUL   = 4'd12;
   localparam logic [3:0] OP_MULHU = 4'd13;
   localparam logic [3:0] OP_DIVU  = 4'd14;
   localparam logic [3:0] OP_REMU  = 4'd15;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
   localparam int unsigned MULDIV_ITERS  = 32;

endpackage

// File: rtl/exec_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step
// per clock over MULDIV_ITERS steps; op[1] selects divide, op[0] the high half.
module exec_muldiv
   import exec_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [4:0] LAST = 5'(MULDIV_ITERS - 1);

   logic [WIDTH-1:0] hi, lo, opnd, hi_n, lo_n;
   logic [WIDTH:0]   mul_sum, div_sh;
   logic [4:0]       count;
   logic             is_div, sel_hi, div_ge;

   // {hi,lo} is the product / {remainder,quotient} pair; a zero divisor
   // always subtracts, yielding an all-ones quotient and remainder = dividend.
   always_comb begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      div_sh  = {hi, lo[WIDTH-1]};
      div_ge  = (div_sh >= {1'b0, opnd});
      if (is_div) begin
         hi_n = div_ge ? WIDTH'(div_sh - {1'b0, opnd}) : div_sh[WIDTH-1:0];
         lo_n = {lo[WIDTH-2:0], div_ge};
      end else begin
         hi_n = mul_sum[WIDTH:1];
         lo_n = {mul_sum[0], lo[WIDTH-1:1]};
      end
      result = sel_hi ? hi_n : lo_n;
   end

   assign done = busy && (count == LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hi     <= '0;
         lo     <= '0;
         opnd   <= '0;
         count  <= '0;
         busy   <= 1'b0;
         is_div <= 1'b0;
         sel_hi <= 1'b0;
      end else if (flush) begin
         busy <= 1'b0;
      end else if (start) begin
         hi     <= '0;
         lo     <= operand_a;
         opnd   <= operand_b;
         count  <= '0;
         busy   <= 1'b1;
         is_div <= op[1];
         sel_hi <= op[0];
      end else if (busy) begin
         hi    <= hi_n;
         lo    <= lo_n;
         count <= count + 5'd1;
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/stage_3_execute.sv
// CPU execute stage: single-cycle ALU, registered memory-control pass-through,
// optional iterative mul/div enabled by macro EXEC_MULDIV_EN.
module stage_3_execute
   import exec_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [WIDTH-1:0] in_reg_data_2,
   input  logic             in_memread,
   input  logic             in_memwrite,
   input  logic [1:0]       in_mem_length,
   input  logic             in_mem_signed,
   output logic             out_valid,
   output logic [WIDTH-1:0] alu_result,
   output logic             zero,
   output logic [WIDTH-1:0] reg_data_2,
   output logic             memread,
   output logic             memwrite,
   output logic [1:0]       mem_length,
   output logic             mem_signed,
   output logic             stall,
   output logic             op_illegal
);

   logic [0:0]       state;
   logic             accept, is_md, md_busy, md_done, md_complete;
   logic [WIDTH-1:0] alu_val, md_result;

   assign is_md       = (alu_op[3:2] == 2'b11);
   assign in_ready    = (state == IDLE);
   assign stall       = (state == RUN);
   assign accept      = in_valid && in_ready && !flush;
   assign md_complete = (state == RUN) && md_busy && md_done && !flush;

`ifdef EXEC_MULDIV_EN
   localparam bit MD_EN = 1'b1;

   exec_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clock     (clock),
      .reset     (reset),
      .start     (accept && is_md),
      .flush     (flush),
      .op        (alu_op[1:0]),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .busy      (md_busy),
      .done      (md_done),
      .result    (md_result)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else if (state == RUN) begin
         if (flush || (md_busy && md_done)) state <= IDLE;
      end else if (accept && is_md) begin
         state <= RUN;
      end
   end
`else
   localparam bit MD_EN = 1'b0;

   assign state     = IDLE;
   assign md_busy   = 1'b0;
   assign md_done   = 1'b0;
   assign md_result = '0;
`endif

   always_comb begin
      alu_val = '0;
      case (alu_op)
         OP_ADD:  alu_val = operand_a + operand_b;
         OP_SUB:  alu_val = operand_a - operand_b;
         OP_AND:  alu_val = operand_a & operand_b;
         OP_OR:   alu_val = operand_a | operand_b;
         OP_XOR:  alu_val = operand_a ^ operand_b;
         OP_NOR:  alu_val = ~(operand_a | operand_b);
         OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
         OP_SLTU: alu_val = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
         OP_SLL:  alu_val = operand_a << operand_b[4:0];
         OP_SRL:  alu_val = operand_a >> operand_b[4:0];
         OP_SRA:  alu_val = $signed(operand_a) >>> operand_b[4:0];
         OP_LUI:  alu_val = {operand_b[15:0], 16'h0000};
         default: alu_val = '0;
      endcase
   end

   // Mul/div ops without the iterative unit retire at once as illegal with a zero result.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid  <= 1'b0;
         alu_result <= '0;
         zero       <= 1'b0;
         op_illegal <= 1'b0;
         reg_data_2 <= '0;
         memread    <= 1'b0;
         memwrite   <= 1'b0;
         mem_length <= '0;
         mem_signed <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (md_complete) begin
            out_valid  <= 1'b1;
            alu_result <= md_result;
            zero       <= (md_result == '0);
            op_illegal <= 1'b0;
         end else if (accept) begin
            reg_data_2 <= in_reg_data_2;
            memread    <= in_memread;
            memwrite   <= in_memwrite;
            mem_length <= in_mem_length;
            mem_signed <= in_mem_signed;
            if (!(is_md && MD_EN)) begin
               out_valid  <= 1'b1;
               alu_result <= alu_val;
               zero       <= (alu_val == '0);
               op_illegal <= is_md;
            end
         end
      end
   end

endmodule

// File: tb/tb_stage_3_execute.sv
// Bench for stage_3_execute: vector table plus scoreboard, with hand-written
// flush / reset / back-to-back sequences; EXEC_MULDIV_EN selects expectations.
`timescale 1ns/1ps
module tb_stage_3_execute;
   import exec_pkg::*;

   localparam int HALF = 5;
   localparam int PER  = 10;
`ifdef EXEC_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   logic        clock, reset, in_valid, in_ready, flush;
   logic [3:0]  alu_op;
   logic [31:0] operand_a, operand_b, in_reg_data_2;
   logic        in_memread, in_memwrite, in_mem_signed;
   logic [1:0]  in_mem_length;
   logic        out_valid, zero, memread, memwrite, mem_signed, stall, op_illegal;
   logic [31:0] alu_result, reg_data_2;
   logic [1:0]  mem_length;

   stage_3_execute #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b),
      .in_reg_data_2(in_reg_data_2), .in_memread(in_memread), .in_memwrite(in_memwrite),
      .in_mem_length(in_mem_length), .in_mem_signed(in_mem_signed),
      .out_valid(out_valid), .alu_result(alu_result), .zero(zero),
      .reg_data_2(reg_data_2), .memread(memread), .memwrite(memwrite),
      .mem_length(mem_length), .mem_signed(mem_signed), .stall(stall),
      .op_illegal(op_illegal)
   );

   initial begin
      clock = 1'b0;
      forever #HALF clock = ~clock;
   end

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b, rd2;
      logic [4:0]  ctl;   // {memread, memwrite, mem_length, mem_signed}
      logic [31:0] res;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        zero, ill;
      logic [31:0] rd2;
      logic [4:0]  ctl;
      time         t_acc;
      int          lat;   // active edges from accept edge to the edge raising out_valid
   } exp_t;

   localparam int NV = 24;
   vec_t tv[NV];
   exp_t sb[$];
   int   n_vec = 0, n_err = 0, n_ov = 0, n_stall = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] rd2, input logic [4:0] ctl, input logic [31:0] res);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.rd2 = rd2; v.ctl = ctl;
      v.res = (op >= 4'd12 && !MD) ? 32'h0 : res;
      return v;
   endfunction

   // Scoreboard side: every out_valid pops one expectation.
   always @(negedge clock) begin
      if (stall) n_stall++;
      if (out_valid) begin
         exp_t e;
         n_ov++;
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_out_valid: got alu_result %0h, required no output", alu_result);
         end else begin
            e = sb.pop_front();
            check("alu_result", alu_result, e.res);
            check("zero", zero, e.zero);
            check("op_illegal", op_illegal, e.ill);
            check("reg_data_2", reg_data_2, e.rd2);
            check("mem_ctl", {memread, memwrite, mem_length, mem_signed}, e.ctl);
            check("latency", ($time - HALF - e.t_acc) / PER, e.lat);
         end
      end
   end

   task automatic issue(input vec_t v, input bit push, output logic ov_at_drive);
      exp_t e;
      int   w;
      w = 0;
      @(negedge clock);
      while (!in_ready && w < 100) begin
         @(negedge clock);
         w++;
      end
      check("issue_in_ready", in_ready, 1'b1);
      ov_at_drive   = out_valid;
      alu_op        = v.op;
      operand_a     = v.a;
      operand_b     = v.b;
      in_reg_data_2 = v.rd2;
      {in_memread, in_memwrite, in_mem_length, in_mem_signed} = v.ctl;
      in_valid      = 1'b1;
      if (push) begin
         e.res   = v.res;
         e.zero  = (v.res == 32'h0);
         e.ill   = (v.op >= 4'd12) && !MD;
         e.rd2   = v.rd2;
         e.ctl   = v.ctl;
         e.t_acc = $time + HALF;
         e.lat   = ((v.op >= 4'd12) && MD) ? 32 : 0;
         sb.push_back(e);
      end
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic wait_empty(input string nm);
      int w;
      w = 0;
      while (sb.size() != 0 && w < 200) begin
         @(negedge clock);
         w++;
      end
      check({nm, "_drained"}, sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      logic ov;
      int   n0, s0;
      #500000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      logic ov;
      int   n0, s0;

      tv[0]  = mk(OP_ADD,   32'h7FFF_FFFF, 32'h1,         32'hDEAD_BEEF, 5'b01100, 32'h8000_0000);
      tv[1]  = mk(OP_SUB,   32'd5,         32'd7,         32'h1111_2222, 5'b10101, 32'hFFFF_FFFE);
      tv[2]  = mk(OP_SUB,   32'd3,         32'd3,         32'h0,         5'b00010, 32'h0);
      tv[3]  = mk(OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'h3333_4444, 5'b11111, 32'hF000_F000);
      tv[4]  = mk(OP_OR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h5555_6666, 5'b00000, 32'hFFF0_FFF0);
      tv[5]  = mk(OP_XOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'h7777_8888, 5'b10011, 32'h0FF0_0FF0);
      tv[6]  = mk(OP_NOR,   32'h0,         32'h0,         32'h9999_AAAA, 5'b01001, 32'hFFFF_FFFF);
      tv[7]  = mk(OP_SLT,   32'h1,         32'hFFFF_FFFF, 32'h1,         5'b00100, 32'h0);
      tv[8]  = mk(OP_SLTU,  32'h1,         32'hFFFF_FFFF, 32'h2,         5'b10000, 32'h1);
      tv[9]  = mk(OP_SLT,   32'hFFFF_FFFF, 32'h1,         32'h3,         5'b01000, 32'h1);
      tv[10] = mk(OP_SLL,   32'h1,         32'h0000_003F, 32'h4,         5'b00001, 32'h8000_0000);
      tv[11] = mk(OP_SRL,   32'h8000_0000, 32'h0000_0024, 32'h5,         5'b11010, 32'h0800_0000);
      tv[12] = mk(OP_SRA,   32'h8000_0000, 32'h0000_0024, 32'h6,         5'b00110, 32'hF800_0000);
      tv[13] = mk(OP_SRA,   32'h7FFF_FFFF, 32'h0000_0004, 32'h7,         5'b10110, 32'h07FF_FFFF);
      tv[14] = mk(OP_LUI,   32'h0,         32'hABCD_1234, 32'h8,         5'b00011, 32'h1234_0000);
      tv[15] = mk(OP_MUL,   32'd3,         32'd4,         32'hCAFE_0001, 5'b01100, 32'd12);
      tv[16] = mk(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hCAFE_0002, 5'b10101, 32'hFFFF_FFFE);
      tv[17] = mk(OP_DIVU,  32'd100,       32'd7,         32'hCAFE_0003, 5'b11000, 32'd14);
      tv[18] = mk(OP_REMU,  32'd100,       32'd7,         32'hCAFE_0004, 5'b00111, 32'd2);
      tv[19] = mk(OP_DIVU,  32'd5,         32'd0,         32'hCAFE_0005, 5'b10010, DIV0_QUOTIENT);
      tv[20] = mk(OP_REMU,  32'd5,         32'd0,         32'hCAFE_0006, 5'b01011, 32'd5);
      tv[21] = mk(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hCAFE_0007, 5'b00000, 32'h1);
      tv[22] = mk(OP_DIVU,  32'h8000_0001, 32'd3,         32'hCAFE_0008, 5'b11111, 32'h2AAA_AAAB);
      tv[23] = mk(OP_REMU,  32'h8000_0001, 32'd3,         32'hCAFE_0009, 5'b00101, 32'h0);

      // Reset held with a valid instruction present.
      reset = 1'b0; flush = 1'b0; in_valid = 1'b1; alu_op = OP_ADD;
      operand_a = 32'h1; operand_b = 32'h1; in_reg_data_2 = 32'hFFFF_FFFF;
      in_memread = 1'b1; in_memwrite = 1'b1; in_mem_length = 2'b11; in_mem_signed = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_alu_result", alu_result, 32'h0);
      check("rst_zero", zero, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_stall", stall, 1'b0);
      check("rst_op_illegal", op_illegal, 1'b0);
      check("rst_passthru", {reg_data_2, memread, memwrite, mem_length, mem_signed}, 37'h0);
      in_valid = 1'b0;
      reset    = 1'b1;

      for (int i = 0; i < NV; i++) issue(tv[i], 1'b1, ov);
      wait_empty("table");

      // Flush while idle must suppress the accept.
      n0 = n_ov;
      @(negedge clock);
      alu_op = OP_ADD; operand_a = 32'd1; operand_b = 32'd2; in_valid = 1'b1; flush = 1'b1;
      @(negedge clock);
      in_valid = 1'b0; flush = 1'b0;
      repeat (3) @(negedge clock);
      check("flush_idle_no_accept", n_ov - n0, 0);

`ifdef EXEC_MULDIV_EN
      // MULHU then DIVU accepted in the MULHU completion cycle.
      s0 = n_stall;
      issue(tv[16], 1'b1, ov);
      check("run_stall", stall, 1'b1);
      check("run_in_ready", in_ready, 1'b0);
      issue(tv[17], 1'b1, ov);
      check("b2b_accept_in_out_valid_cycle", ov, 1'b1);
      wait_empty("b2b");
      check("stall_cycles", n_stall - s0, 64);

      // Flush in the tenth RUN cycle.
      n0 = n_ov;
      issue(tv[17], 1'b0, ov);
      repeat (9) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      check("flush_run_stall", stall, 1'b0);
      check("flush_run_in_ready", in_ready, 1'b1);
      repeat (40) @(negedge clock);
      check("flush_run_no_out_valid", n_ov - n0, 0);

      // Flush coinciding with the final iteration discards the completion.
      n0 = n_ov;
      issue(tv[16], 1'b0, ov);
      repeat (31) @(negedge clock);
      check("last_iter_still_running", stall, 1'b1);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      check("flush_last_in_ready", in_ready, 1'b1);
      repeat (10) @(negedge clock);
      check("flush_last_no_out_valid", n_ov - n0, 0);

      // Asynchronous reset at RUN cycle 20.
      n0 = n_ov;
      issue(tv[19], 1'b0, ov);
      repeat (19) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check("async_rst_stall", stall, 1'b0);
      check("async_rst_in_ready", in_ready, 1'b1);
      check("async_rst_out_valid", out_valid, 1'b0);
      check("async_rst_reg_data_2", reg_data_2, 32'h0);
      @(negedge clock);
      reset = 1'b1;
      repeat (40) @(negedge clock);
      check("async_rst_no_out_valid", n_ov - n0, 0);
`else
      check("no_stall_ever", n_stall, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
